// File: rtl/store_drain_queue_pkg.sv
// Shared constants and types for the store drain queue.
//   ADDR_LEN / DATA_LEN : data-memory address and word widths
//   STQ_DEPTH / STQ_PTR_W : default queue depth and pointer width
//   stq_entry_t : one buffered store {addr, data}
package store_drain_queue_pkg;

  localparam int ADDR_LEN  = 32;
  localparam int DATA_LEN  = 32;

  localparam int STQ_DEPTH = 4;
  localparam int STQ_PTR_W = 2;

  typedef struct packed {
    logic [ADDR_LEN-1:0] addr;
    logic [DATA_LEN-1:0] data;
  } stq_entry_t;

endpackage

// File: rtl/stq_fwd_match.sv
// Youngest-match search over the occupied queue entries.
//   entries : queue storage, indexed by physical slot
//   head    : slot of the oldest entry
//   count   : number of occupied entries (0..DEPTH)
//   ld_addr : load address to match (full-width compare)
//   hit     : some occupied entry matches ld_addr
//   data    : data of the youngest matching entry (0 when no hit)
module stq_fwd_match
  import store_drain_queue_pkg::*;
#(
  parameter int DEPTH = STQ_DEPTH,
  parameter int PTR_W = STQ_PTR_W
) (
  input  stq_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]       head,
  input  logic [PTR_W:0]         count,
  input  logic [ADDR_LEN-1:0]    ld_addr,
  output logic                   hit,
  output logic [DATA_LEN-1:0]    data
);

  // Walk oldest to youngest; a later match overwrites an earlier one, so the
  // survivor is the youngest. Slot index wraps naturally at PTR_W bits.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) &&
          (entries[head + PTR_W'(i)].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[head + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/store_drain_queue.sv
// Committed-store buffer in front of the single-port data memory.
// Buffers stores, drains them in order whenever no load takes the port,
// and forwards queued data so loads always see the newest committed value.
//   clk, reset          : clock, async active-high reset
//   st_valid/addr/data  : store enqueue; st_full back-pressures commit
//   ld_req/ld_addr      : load request; ld_stall when not accepted
//   ld_valid/ld_data    : load response, one cycle after acceptance
//   dmem_*              : memory port (1-cycle registered read)
//   drained             : queue empty
module store_drain_queue
  import store_drain_queue_pkg::*;
#(
  parameter int DEPTH = STQ_DEPTH,
  parameter int PTR_W = STQ_PTR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                st_valid,
  input  logic [ADDR_LEN-1:0] st_addr,
  input  logic [DATA_LEN-1:0] st_data,
  output logic                st_full,
  input  logic                ld_req,
  input  logic [ADDR_LEN-1:0] ld_addr,
  output logic                ld_stall,
  output logic                ld_valid,
  output logic [DATA_LEN-1:0] ld_data,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [DATA_LEN-1:0] dmem_wdata,
  output logic                dmem_we,
  input  logic [DATA_LEN-1:0] dmem_rdata,
  output logic                drained
);

  stq_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [PTR_W:0]         count;

  logic                   enq;
  logic                   ld_acc;
  logic                   drain;

  logic                   q_hit;
  logic [DATA_LEN-1:0]    q_data;
  logic                   fwd_hit;
  logic [DATA_LEN-1:0]    fwd_data;
  logic                   fwd_hit_q;
  logic [DATA_LEN-1:0]    fwd_data_q;

  assign st_full = (count == (PTR_W+1)'(DEPTH));
  assign drained = (count == '0);

  // A full queue hands the port to the drain so commit can never deadlock
  // behind a stream of loads.
  assign enq      = st_valid && !st_full;
  assign ld_acc   = ld_req && !st_full;
  assign ld_stall = ld_req && st_full;
  assign drain    = !ld_acc && (count != '0);

  assign dmem_we    = drain;
  assign dmem_addr  = drain ? entries[head].addr : ld_addr;
  assign dmem_wdata = entries[head].data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (enq) begin
        entries[tail] <= '{addr: st_addr, data: st_data};
        tail          <= tail + 1'b1;
      end
      if (drain) begin
        head <= head + 1'b1;
      end
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  stq_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .entries (entries),
    .head    (head),
    .count   (count),
    .ld_addr (ld_addr),
    .hit     (q_hit),
    .data    (q_data)
  );

  // A store entering this very cycle is younger than anything queued.
  always_comb begin
    fwd_hit  = q_hit;
    fwd_data = q_data;
    if (enq && (st_addr == ld_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = st_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_valid   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      ld_valid  <= ld_acc;
      fwd_hit_q <= ld_acc && fwd_hit;
      if (ld_acc) begin
        fwd_data_q <= fwd_data;
      end
    end
  end

  // Held at zero between responses so the bus is quiet after reset.
  assign ld_data = !ld_valid ? '0 : (fwd_hit_q ? fwd_data_q : dmem_rdata);

  st_full_protocol : assert property (
    @(posedge clk) disable iff (reset) !(st_valid && st_full)
  ) else $error("store_drain_queue: store offered while queue full was dropped");

endmodule

// File: tb/tb_store_drain_queue.sv
module tb_store_drain_queue;
  import store_drain_queue_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                st_valid;
  logic [ADDR_LEN-1:0] st_addr;
  logic [DATA_LEN-1:0] st_data;
  logic                st_full;
  logic                ld_req;
  logic [ADDR_LEN-1:0] ld_addr;
  logic                ld_stall;
  logic                ld_valid;
  logic [DATA_LEN-1:0] ld_data;
  logic [ADDR_LEN-1:0] dmem_addr;
  logic [DATA_LEN-1:0] dmem_wdata;
  logic                dmem_we;
  logic [DATA_LEN-1:0] dmem_rdata;
  logic                drained;

  int total = 0;
  int bad   = 0;

  store_drain_queue dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_full    (st_full),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_stall   (ld_stall),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  // Data memory environment: 2048 words, registered read.
  logic                mem_load;
  logic [DATA_LEN-1:0] mem     [2048];
  logic [DATA_LEN-1:0] ref_mem [2048];   // newest committed value per word
  logic [63:0]         wr_log  [$];

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
    end else if (dmem_we) begin
      mem[dmem_addr[10:0]] <= dmem_wdata;
    end else begin
      dmem_rdata <= mem[dmem_addr[10:0]];
    end
  end

  always @(posedge clk) begin
    if (!reset && dmem_we) wr_log.push_back({dmem_addr, dmem_wdata});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; st_valid = 1'b0; ld_req = 1'b0;
    st_addr = '0; st_data = '0; ld_addr = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; st_valid = 1'b0; ld_req = 1'b0;
    #1;
    total++; if (st_full !== 1'b0) begin bad++; $display("FAIL rst_st_full: got %b want 0", st_full); end
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL rst_drained: got %b want 1", drained); end
    total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL rst_ld_valid: got %b want 0", ld_valid); end
    total++; if (ld_data !== '0) begin bad++; $display("FAIL rst_ld_data: got %h want 0", ld_data); end
    total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL rst_dmem_we: got %b want 0", dmem_we); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
  endtask

  task automatic test_basic();
    do_reset();
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAAAA;
    #1;
    total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL basic_empty_we: got %b want 0", dmem_we); end
    ref_mem[16] = 32'hAAAA;
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    total++; if (dmem_we !== 1'b1) begin bad++; $display("FAIL basic_drain_we: got %b want 1", dmem_we); end
    total++; if (dmem_addr !== 32'h10) begin bad++; $display("FAIL basic_drain_addr: got %h want 10", dmem_addr); end
    total++; if (dmem_wdata !== 32'hAAAA) begin bad++; $display("FAIL basic_drain_data: got %h want aaaa", dmem_wdata); end
    total++; if (drained !== 1'b0) begin bad++; $display("FAIL basic_not_drained: got %b want 0", drained); end
    @(negedge clk);
    #1;
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL basic_drained: got %b want 1", drained); end
    total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL basic_idle_we: got %b want 0", dmem_we); end
    ld_req = 1'b1; ld_addr = 32'h10;
    #1;
    total++; if (ld_stall !== 1'b0) begin bad++; $display("FAIL basic_ld_stall: got %b want 0", ld_stall); end
    total++; if (dmem_addr !== 32'h10) begin bad++; $display("FAIL basic_ld_addr: got %h want 10", dmem_addr); end
    @(negedge clk);
    ld_req = 1'b0;
    #1;
    total++; if (ld_valid !== 1'b1) begin bad++; $display("FAIL basic_ld_valid: got %b want 1", ld_valid); end
    total++; if (ld_data !== ref_mem[16]) begin bad++; $display("FAIL basic_ld_data: got %h want %h", ld_data, ref_mem[16]); end
    total++; if (dut.fwd_hit_q !== 1'b0) begin bad++; $display("FAIL basic_fwd_hit: got %b want 0", dut.fwd_hit_q); end
  endtask

  task automatic test_youngest();
    do_reset();
    ld_req = 1'b1; ld_addr = 32'h30;
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'd1;
    #1;
    total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL young_ld_wins: got %b want 0", dmem_we); end
    @(negedge clk);
    st_data = 32'd2;
    #1;
    total++; if (ld_valid !== 1'b1) begin bad++; $display("FAIL young_ld30_valid: got %b want 1", ld_valid); end
    total++; if (ld_data !== ref_mem[48]) begin bad++; $display("FAIL young_ld30_data: got %h want %h", ld_data, ref_mem[48]); end
    @(negedge clk);
    st_valid = 1'b0; ld_addr = 32'h20;
    #1;
    total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL young_hold_port: got %b want 0", dmem_we); end
    @(negedge clk);
    ld_req = 1'b0;
    #1;
    total++; if (ld_valid !== 1'b1) begin bad++; $display("FAIL young_ld_valid: got %b want 1", ld_valid); end
    total++; if (ld_data !== 32'd2) begin bad++; $display("FAIL young_ld_data: got %h want 2", ld_data); end
    total++; if (mem[32] !== init_word(32)) begin bad++; $display("FAIL young_mem_untouched: got %h want %h", mem[32], init_word(32)); end
    total++; if (dmem_wdata !== 32'd1 || dmem_we !== 1'b1) begin bad++; $display("FAIL young_drain1: got we=%b d=%h want we=1 d=1", dmem_we, dmem_wdata); end
    @(negedge clk);
    #1;
    total++; if (dmem_wdata !== 32'd2 || dmem_we !== 1'b1) begin bad++; $display("FAIL young_drain2: got we=%b d=%h want we=1 d=2", dmem_we, dmem_wdata); end
    ref_mem[32] = 32'd2;
    @(negedge clk);
    #1;
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL young_drained: got %b want 1", drained); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h55;
    ld_req = 1'b1; ld_addr = 32'h40;
    ref_mem[64] = 32'h55;
    @(negedge clk);
    st_valid = 1'b0; ld_req = 1'b0;
    #1;
    total++; if (ld_valid !== 1'b1) begin bad++; $display("FAIL same_ld_valid: got %b want 1", ld_valid); end
    total++; if (ld_data !== 32'h55) begin bad++; $display("FAIL same_ld_data: got %h want 55", ld_data); end
    @(negedge clk);
  endtask

  task automatic test_full_wrap();
    int start;
    do_reset();
    start = wr_log.size();
    ld_req = 1'b1; ld_addr = 32'h50;
    for (int k = 0; k < 4; k++) begin
      st_valid = 1'b1; st_addr = 32'h60 + 32'(k); st_data = 32'h100 + 32'(k);
      ref_mem[96 + k] = st_data;
      @(negedge clk);
    end
    st_valid = 1'b0;
    #1;
    total++; if (st_full !== 1'b1) begin bad++; $display("FAIL full_st_full: got %b want 1", st_full); end
    total++; if (ld_stall !== 1'b1) begin bad++; $display("FAIL full_ld_stall: got %b want 1", ld_stall); end
    total++; if (dmem_we !== 1'b1 || dmem_addr !== 32'h60) begin bad++; $display("FAIL full_head_drain: got we=%b a=%h want we=1 a=60", dmem_we, dmem_addr); end
    @(negedge clk);
    #1;
    total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL full_stalled_valid: got %b want 0", ld_valid); end
    total++; if (st_full !== 1'b0 || ld_stall !== 1'b0) begin bad++; $display("FAIL full_release: got full=%b stall=%b want 0 0", st_full, ld_stall); end
    total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL full_load_wins: got %b want 0", dmem_we); end
    @(negedge clk);
    ld_req = 1'b0;
    #1;
    total++; if (ld_valid !== 1'b1) begin bad++; $display("FAIL full_ld_valid: got %b want 1", ld_valid); end
    total++; if (ld_data !== ref_mem[80]) begin bad++; $display("FAIL full_ld_data: got %h want %h", ld_data, ref_mem[80]); end
    for (int k = 4; k < 7; k++) begin
      st_valid = 1'b1; st_addr = 32'h60 + 32'(k); st_data = 32'h100 + 32'(k);
      ref_mem[96 + k] = st_data;
      @(negedge clk);
      #1;
      total++; if (dut.count !== 3'd3) begin bad++; $display("FAIL wrap_count: got %0d want 3", dut.count); end
    end
    st_valid = 1'b0;
    for (int n = 0; n < 12 && drained !== 1'b1; n++) @(negedge clk);
    #1;
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL wrap_drain_timeout: got %b want 1", drained); end
    total++; if (wr_log.size() - start !== 7) begin bad++; $display("FAIL wrap_write_count: got %0d want 7", wr_log.size() - start); end
    for (int k = 0; k < 7 && start + k < wr_log.size(); k++) begin
      total++;
      if (wr_log[start + k] !== {32'h60 + 32'(k), 32'h100 + 32'(k)}) begin
        bad++; $display("FAIL wrap_order_%0d: got %h want %h", k, wr_log[start + k], {32'h60 + 32'(k), 32'h100 + 32'(k)});
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr_before;
    do_reset();
    ld_req = 1'b1; ld_addr = 32'h80;
    for (int k = 0; k < 3; k++) begin
      st_valid = 1'b1; st_addr = 32'h90 + 32'(k); st_data = 32'h900 + 32'(k);
      @(negedge clk);
    end
    st_valid = 1'b0; ld_req = 1'b0;
    #1;
    total++; if (ld_valid !== 1'b1 || drained !== 1'b0) begin bad++; $display("FAIL mid_pre: got v=%b dr=%b want 1 0", ld_valid, drained); end
    wr_before = wr_log.size();
    reset = 1'b1;
    #1;
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL mid_drained: got %b want 1", drained); end
    total++; if (ld_valid !== 1'b0 || ld_data !== '0) begin bad++; $display("FAIL mid_ld_clear: got v=%b d=%h want 0 0", ld_valid, ld_data); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (wr_log.size() !== wr_before) begin bad++; $display("FAIL mid_no_writes: got %0d want %0d", wr_log.size(), wr_before); end
    total++; if (mem[144] !== init_word(144)) begin bad++; $display("FAIL mid_mem_90: got %h want %h", mem[144], init_word(144)); end
    for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
  endtask

  // Model: queue of pending stores in commit order plus the newest
  // committed value per word; loads must return that value.
  task automatic test_random();
    stq_entry_t exp_q[$];
    logic pend_v;
    logic [DATA_LEN-1:0] pend_d;
    logic full, acc, drn;
    do_reset();
    pend_v = 1'b0; pend_d = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      full     = (exp_q.size() == STQ_DEPTH);
      st_valid = !full && ($urandom_range(0, 99) < 55);
      st_addr  = 32'h200 + 32'($urandom_range(0, 7));
      st_data  = $urandom;
      ld_req   = ($urandom_range(0, 99) < 45);
      ld_addr  = 32'h200 + 32'($urandom_range(0, 7));
      #1;
      acc = ld_req && !full;
      drn = !acc && (exp_q.size() != 0);
      total++; if (ld_valid !== pend_v) begin bad++; $display("FAIL rnd_ld_valid c%0d: got %b want %b", cyc, ld_valid, pend_v); end
      if (pend_v) begin
        total++; if (ld_data !== pend_d) begin bad++; $display("FAIL rnd_ld_data c%0d: got %h want %h", cyc, ld_data, pend_d); end
      end
      total++; if (st_full !== full) begin bad++; $display("FAIL rnd_st_full c%0d: got %b want %b", cyc, st_full, full); end
      total++; if (drained !== (exp_q.size() == 0)) begin bad++; $display("FAIL rnd_drained c%0d: got %b want %b", cyc, drained, exp_q.size() == 0); end
      total++; if (ld_stall !== (ld_req && full)) begin bad++; $display("FAIL rnd_ld_stall c%0d: got %b want %b", cyc, ld_stall, ld_req && full); end
      total++; if (dmem_we !== drn) begin bad++; $display("FAIL rnd_dmem_we c%0d: got %b want %b", cyc, dmem_we, drn); end
      if (drn) begin
        total++;
        if (dmem_addr !== exp_q[0].addr || dmem_wdata !== exp_q[0].data) begin
          bad++; $display("FAIL rnd_drain c%0d: got %h/%h want %h/%h", cyc, dmem_addr, dmem_wdata, exp_q[0].addr, exp_q[0].data);
        end
      end
      if (acc) begin
        total++; if (dmem_addr !== ld_addr) begin bad++; $display("FAIL rnd_ld_addr c%0d: got %h want %h", cyc, dmem_addr, ld_addr); end
      end
      if (st_valid) begin
        exp_q.push_back('{addr: st_addr, data: st_data});
        ref_mem[st_addr[10:0]] = st_data;
      end
      pend_v = acc;
      if (acc) pend_d = ref_mem[ld_addr[10:0]];
      if (drn) void'(exp_q.pop_front());
      @(negedge clk);
    end
    st_valid = 1'b0; ld_req = 1'b0;
    for (int n = 0; n < 12 && drained !== 1'b1; n++) @(negedge clk);
    #1;
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL rnd_drain_timeout: got %b want 1", drained); end
    for (int a = 0; a < 8; a++) begin
      total++;
      if (mem[512 + a] !== ref_mem[512 + a]) begin
        bad++; $display("FAIL rnd_mem_%0d: got %h want %h", a, mem[512 + a], ref_mem[512 + a]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; ld_req = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    test_reset();
    test_basic();
    test_youngest();
    test_same_cycle();
    test_full_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_drain_queue.md
Name: store_drain_queue

Overview:
- Sits directly upstream of the 8KB single-port data memory (2048 x DATA_LEN words, word index = addr[10:0], 1-cycle registered read) and owns its only port.
- Buffers committed stores in a FIFO and drains them to memory one per cycle whenever no load needs the port.
- Arbitrates loads against drains and forwards buffered store data to loads, so a load always returns the newest committed value.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- st_valid  in  1  committed store enqueue request
- st_addr  in  ADDR_LEN  store word address
- st_data  in  DATA_LEN  store data
- st_full  out  1  queue full; commit must hold the store
- ld_req  in  1  load request
- ld_addr  in  ADDR_LEN  load word address
- ld_stall  out  1  load not accepted this cycle
- ld_valid  out  1  load data valid (one cycle after acceptance)
- ld_data  out  DATA_LEN  load result
- dmem_addr  out  ADDR_LEN  memory address
- dmem_wdata  out  DATA_LEN  memory write data
- dmem_we  out  1  memory write enable
- dmem_rdata  in  DATA_LEN  memory read data (registered, 1-cycle latency)
- drained  out  1  queue empty, for fence/halt

Behaviour:
- Reset (async):
  - head, tail and count are 0; all entries are invalid.
  - Outputs: st_full=0, drained=1, ld_valid=0, ld_data=0, fwd_hit_q=0, fwd_data_q=0.
- State: circular FIFO of {addr, data}; head=oldest, tail=next free; count is 0..DEPTH, PTR_W+1 bits.
- Status flags:
  - st_full = (count==DEPTH).
  - drained = (count==0).
  - Both are registered-state derived, with no combinational path from inputs.
- Enqueue: when st_valid && !st_full, write entry[tail], then tail = tail+1 (wraps mod DEPTH).
  - st_valid while st_full is a protocol violation: the store is ignored, state is unchanged, and a simulation assertion fires.
- Port arbitration each cycle:
  - ld_req && !st_full: the load wins. dmem_addr=ld_addr, dmem_we=0, ld_stall=0.
  - ld_req && st_full: the drain wins and ld_stall=1. This guarantees forward progress.
  - Drain selected and count!=0: dmem_addr=entry[head].addr, dmem_wdata=entry[head].data, dmem_we=1, then head = head+1.
  - Otherwise dmem_we=0 and dmem_addr = ld_addr.
- Count update:
  - +1 on enqueue, -1 on drain, unchanged when both occur in the same cycle.
  - Enqueue and drain in the same cycle when count==DEPTH-1 leaves count at DEPTH-1.
- Forwarding (accepted load, combinational match in the acceptance cycle):
  - Priority 1: a same-cycle enqueue with st_addr==ld_addr, taking st_data.
  - Priority 2: the youngest valid entry with a matching address, scanning from tail-1 back to head.
  - Full ADDR_LEN comparison.
  - The result is registered into fwd_hit_q/fwd_data_q.
- Load response:
  - ld_valid is asserted exactly one cycle after acceptance.
  - ld_data = fwd_hit_q ? fwd_data_q : dmem_rdata.
  - ld_valid=0 whenever the load was stalled.
- Write ordering: drains happen strictly in FIFO order. An entry still in the queue never has its address in memory stale relative to a load, because forwarding covers it.
- Reset mid-operation: all queued stores are discarded, and any pending ld_valid is cleared immediately.

Decomposition:
- Shared constants header (existing): ADDR_LEN, DATA_LEN.
- Add STQ_DEPTH and STQ_PTR_W defaults there.
- One natural sub-module: stq_fwd_match, a combinational youngest-match priority search over the entries given head, count and ld_addr, returning hit and data.
- FIFO storage, arbitration and the response register stay in the top level.

Test Plan:
- Store addr 0x10 data 0xAAAA, idle 2 cycles -> dmem_we=1 with addr 0x10 in the cycle after enqueue; drained returns to 1; a later load of 0x10 returns 0xAAAA from memory with fwd_hit_q=0.
- Stores 0x20=1 then 0x20=2 enqueued back to back while ld_req at 0x30 holds the port, then load 0x20 -> ld_data=2 one cycle later (youngest match); memory untouched.
- Same cycle: st_valid 0x40=0x55 and ld_req 0x40 -> next-cycle ld_valid=1, ld_data=0x55.
- Fill DEPTH=4 entries with ld_req held high -> st_full=1 and ld_stall=1; the head drains (dmem_we=1); the next cycle the load is accepted and ld_valid follows.
- Enqueue while draining at count=3 -> count stays 3; tail and head wrap past index 3 to 0; drain order matches enqueue order.
- Assert reset with 3 entries queued and a load in flight -> drained=1, ld_valid=0 immediately, and no further dmem_we.
